// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column drive, frame-level ghost rejection,
// debounce and registered one-hot / start / stop decode for the controller.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 1,
  parameter int unsigned DEBOUNCE_SCANS = 3,
  parameter int unsigned CNT_W          = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [2:0] col_n,
  output logic [9:0] keypad,
  output logic       startn,
  output logic       stopn,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam logic [3:0]       NONE     = 4'hF;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic {RELEASED, PRESSED} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [11:0]      acc_q, acc_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       key_code_q, key_code_d;
  logic [9:0]       keypad_q, keypad_d;
  logic             startn_q, startn_d;
  logic             stopn_q, stopn_d;
  logic             key_valid_q, key_valid_d;

  logic [2:0]  col_oh;
  logic [3:0]  hit;
  logic [11:0] frame_bits;
  logic [3:0]  frame_code;
  logic        sample;
  logic        upd;

  always_comb begin
    col_oh      = 3'b001 << col_q;
    hit         = ~row_n;
    sample      = (div_q == DIV_LAST);
    div_d       = div_q;
    col_d       = col_q;
    acc_d       = acc_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    key_valid_d = 1'b0;
    frame_code  = NONE;

    // Key position r*3+c: each row owns a 3-bit group, one bit per column.
    frame_bits = acc_q;
    if (sample) begin
      frame_bits = acc_q | {{3{hit[3]}} & col_oh, {3{hit[2]}} & col_oh,
                            {3{hit[1]}} & col_oh, {3{hit[0]}} & col_oh};
    end

    if (frame_bits != '0 && (frame_bits & (frame_bits - 12'd1)) == '0) begin
      unique case (frame_bits)
        12'h001: frame_code = 4'd1;
        12'h002: frame_code = 4'd2;
        12'h004: frame_code = 4'd3;
        12'h008: frame_code = 4'd4;
        12'h010: frame_code = 4'd5;
        12'h020: frame_code = 4'd6;
        12'h040: frame_code = 4'd7;
        12'h080: frame_code = 4'd8;
        12'h100: frame_code = 4'd9;
        12'h200: frame_code = 4'd10;
        12'h400: frame_code = 4'd0;
        12'h800: frame_code = 4'd11;
        default: frame_code = NONE;
      endcase
    end

    if (sample) begin
      div_d = '0;
      if (col_q == 2'd2) begin
        col_d = 2'd0;
        acc_d = '0;
        if (frame_code == cand_q) begin
          cnt_d = (cnt_q == DEB_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
          cand_d = frame_code;
          cnt_d  = CNT_W'(1);
        end
      end else begin
        col_d = col_q + 2'd1;
        acc_d = frame_bits;
      end
    end else begin
      div_d = div_q + CNT_W'(1);
    end

    upd        = (cnt_q == DEB_MAX) && (cand_q != key_code_q);
    key_code_d = upd ? cand_q : key_code_q;

    unique case (state_q)
      RELEASED: begin
        if (upd && cand_q != NONE) begin
          state_d     = PRESSED;
          key_valid_d = 1'b1;
        end
      end
      PRESSED: begin
        if (upd) begin
          if (cand_q == NONE) state_d = RELEASED;
          else                key_valid_d = 1'b1;
        end
      end
      default: state_d = RELEASED;
    endcase

    // Decode from the next key_code so outputs move in the same cycle it does.
    keypad_d = '0;
    if (key_code_d <= 4'd9) keypad_d = 10'b1 << key_code_d;
    startn_d = (key_code_d != 4'd11);
    stopn_d  = (key_code_d != 4'd10);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RELEASED;
      div_q       <= '0;
      col_q       <= '0;
      acc_q       <= '0;
      cand_q      <= NONE;
      cnt_q       <= '0;
      key_code_q  <= NONE;
      keypad_q    <= '0;
      startn_q    <= 1'b1;
      stopn_q     <= 1'b1;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      col_q       <= col_d;
      acc_q       <= acc_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      keypad_q    <= keypad_d;
      startn_q    <= startn_d;
      stopn_q     <= stopn_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign col_n     = ~col_oh;
  assign keypad    = keypad_q;
  assign startn    = startn_q;
  assign stopn     = stopn_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model answers the column drive,
// stimulus queues each expected output event, a negedge monitor pops and checks.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row_n;
  logic [2:0] col_n;
  logic [9:0] keypad;
  logic       startn, stopn, key_valid;
  logic [3:0] key_code;

  // Pressed keys by position r*3+c (r0: 1 2 3, r1: 4 5 6, r2: 7 8 9, r3: * 0 #)
  logic [11:0] pressed = '0;

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  code;
    logic [9:0]  kp;
    logic        sn;
    logic        spn;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  keypad_scanner #(
    .SCAN_DIV(1),
    .DEBOUNCE_SCANS(3),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .row_n(row_n),
    .col_n(col_n),
    .keypad(keypad),
    .startn(startn),
    .stopn(stopn),
    .key_valid(key_valid),
    .key_code(key_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign row_n[0] = ~|(pressed[2:0]   & ~col_n);
  assign row_n[1] = ~|(pressed[5:3]   & ~col_n);
  assign row_n[2] = ~|(pressed[8:6]   & ~col_n);
  assign row_n[3] = ~|(pressed[11:9]  & ~col_n);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic push(input int unsigned c, input logic [3:0] code, input logic [9:0] kp,
                      input logic sn, input logic spn, input logic v);
    exp_t x;
    x.cyc = c; x.code = code; x.kp = kp; x.sn = sn; x.spn = spn; x.valid = v;
    exp_q.push_back(x);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Returns the cycle count at the negedge inside the next column-0 dwell.
  task automatic frame_start(output int unsigned f);
    int unsigned n = 0;
    @(negedge clk);
    while (col_n !== 3'b110 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (col_n !== 3'b110) begin
      n_checks++;
      $display("FAIL frame_start_timeout: col_n=%b, required 110", col_n);
    end
    f = cyc;
  endtask

  // Monitor: any output change or key_valid pulse must match the next queued event.
  logic [3:0] p_code = 4'hF;
  logic [9:0] p_kp = '0;
  logic       p_sn = 1'b1, p_spn = 1'b1;

  always @(negedge clk) begin
    if (key_code !== p_code || keypad !== p_kp || startn !== p_sn ||
        stopn !== p_spn || key_valid !== 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event: key_code=%0d keypad=%b startn=%b stopn=%b key_valid=%b at cycle %0d, required no change",
                 key_code, keypad, startn, stopn, key_valid, cyc);
      end else begin
        e = exp_q.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("key_code", 32'(key_code), 32'(e.code));
        check("keypad", 32'(keypad), 32'(e.kp));
        check("startn", 32'(startn), 32'(e.sn));
        check("stopn", 32'(stopn), 32'(e.spn));
        check("key_valid", 32'(key_valid), 32'(e.valid));
      end
    end
    p_code = key_code;
    p_kp   = keypad;
    p_sn   = startn;
    p_spn  = stopn;
  end

  initial begin
    int unsigned f, g, n;
    #1 reset = 1'b1;
    #2;
    check("rst_key_code", 32'(key_code), 32'd15);
    check("rst_keypad", 32'(keypad), 32'd0);
    check("rst_col_n", 32'(col_n), 32'b110);
    check("rst_startn", 32'(startn), 32'd1);
    check("rst_stopn", 32'(stopn), 32'd1);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    idle(2);
    reset = 1'b0;
    idle(12);

    // Single digit '1'
    frame_start(f); pressed = 12'h001;
    push(f + 10, 4'd1, 10'b0000000010, 1'b1, 1'b1, 1'b1);
    idle(20);
    frame_start(f); pressed = '0;
    push(f + 10, 4'd15, 10'b0, 1'b1, 1'b1, 1'b0);
    idle(15);

    // '#' then '*'
    frame_start(f); pressed = 12'h800;
    push(f + 10, 4'd11, 10'b0, 1'b0, 1'b1, 1'b1);
    idle(15);
    frame_start(f); pressed = '0;
    push(f + 10, 4'd15, 10'b0, 1'b1, 1'b1, 1'b0);
    idle(15);
    frame_start(f); pressed = 12'h200;
    push(f + 10, 4'd10, 10'b0, 1'b1, 1'b0, 1'b1);
    idle(15);
    frame_start(f); pressed = '0;
    push(f + 10, 4'd15, 10'b0, 1'b1, 1'b1, 1'b0);
    idle(15);

    // Bounce on '2': six toggling frames, then a steady hold
    for (int i = 0; i < 6; i++) begin
      frame_start(f);
      pressed = (i % 2 == 0) ? 12'h002 : 12'h000;
    end
    frame_start(f); pressed = 12'h002;
    push(f + 10, 4'd2, 10'b0000000100, 1'b1, 1'b1, 1'b1);
    idle(15);
    frame_start(f); pressed = '0;
    push(f + 10, 4'd15, 10'b0, 1'b1, 1'b1, 1'b0);
    idle(15);

    // Ghost: '3' + '0' rejected, then '3' alone
    frame_start(f); pressed = 12'h404;
    idle(18);
    frame_start(f); pressed = 12'h004;
    push(f + 10, 4'd3, 10'b0000001000, 1'b1, 1'b1, 1'b1);
    idle(15);
    frame_start(f); pressed = '0;
    push(f + 10, 4'd15, 10'b0, 1'b1, 1'b1, 1'b0);
    idle(15);

    // Digit '5' together with '#': never a start
    frame_start(f); pressed = 12'h810;
    idle(18);
    frame_start(f); pressed = '0;
    idle(15);

    // Roll-over '4' -> '7' with a three-frame overlap (stable NONE between)
    frame_start(f); pressed = 12'h008;
    push(f + 10, 4'd4, 10'b0000010000, 1'b1, 1'b1, 1'b1);
    idle(12);
    frame_start(f); pressed = 12'h048;
    push(f + 10, 4'd15, 10'b0, 1'b1, 1'b1, 1'b0);
    push(f + 19, 4'd7, 10'b0010000000, 1'b1, 1'b1, 1'b1);
    repeat (3) frame_start(g);
    pressed = 12'h040;
    idle(12);

    // Direct roll-over '7' -> '1' with a one-frame overlap
    frame_start(g); pressed = 12'h041;
    frame_start(f); pressed = 12'h001;
    push(g + 13, 4'd1, 10'b0000000010, 1'b1, 1'b1, 1'b1);
    idle(12);
    frame_start(f); pressed = '0;
    push(f + 10, 4'd15, 10'b0, 1'b1, 1'b1, 1'b0);
    idle(15);

    // Reset mid-operation while '5' is held
    frame_start(f); pressed = 12'h010;
    push(f + 10, 4'd5, 10'b0000100000, 1'b1, 1'b1, 1'b1);
    idle(13);
    @(negedge clk);
    push(cyc + 1, 4'd15, 10'b0, 1'b1, 1'b1, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("async_rst_key_code", 32'(key_code), 32'd15);
    check("async_rst_keypad", 32'(keypad), 32'd0);
    check("async_rst_col_n", 32'(col_n), 32'b110);
    idle(2);
    push(cyc + 10, 4'd5, 10'b0000100000, 1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    idle(14);
    frame_start(f); pressed = '0;
    push(f + 10, 4'd15, 10'b0, 1'b1, 1'b1, 1'b0);
    idle(15);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      $display("FAIL missing_event: key_code=%0d expected at cycle %0d never seen", e.code, e.cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
